// File: rtl/nec_ir_rx.sv
// nec_ir_rx: NEC infrared protocol receiver.
// Samples the demodulated IR line through a 2-flop synchroniser, times every
// low/high phase with a single counter and decodes lead, 32 data bits, stop
// burst and repeat codes. Build-time option: define IR_EXT_ADDR_EN for
// extended NEC (16-bit address, no address-inverse check).
module nec_ir_rx #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TOL_PCT     = 20,
    parameter int RPT_WIN_MS  = 120
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        inf_in,
    output logic [15:0] addr,
    output logic [7:0]  cmd,
    output logic        data_valid,
    output logic        repeat_en,
    output logic        frame_err,
    output logic        busy
);

    // duration helpers: microseconds to cycles, and acceptance window bounds
    function automatic longint nom_cyc(input longint us);
        return (longint'(CLK_FREQ_HZ) * us) / 64'sd1000000;
    endfunction

    function automatic longint win_lo(input longint n);
        return (n * longint'(100 - TOL_PCT)) / 64'sd100;
    endfunction

    function automatic longint win_hi(input longint n);
        return (n * longint'(100 + TOL_PCT)) / 64'sd100;
    endfunction

    // the counter stops one past the widest window so a stuck line is visible
    localparam longint SAT_L = win_hi(nom_cyc(64'sd9000)) + 64'sd1;
    localparam int     CW    = $clog2(SAT_L + 64'sd1);

    localparam logic [CW-1:0] SAT      = CW'(SAT_L);
    localparam logic [CW-1:0] L9_MIN   = CW'(win_lo(nom_cyc(64'sd9000)));
    localparam logic [CW-1:0] L9_MAX   = CW'(win_hi(nom_cyc(64'sd9000)));
    localparam logic [CW-1:0] H45_MIN  = CW'(win_lo(nom_cyc(64'sd4500)));
    localparam logic [CW-1:0] H45_MAX  = CW'(win_hi(nom_cyc(64'sd4500)));
    localparam logic [CW-1:0] H225_MIN = CW'(win_lo(nom_cyc(64'sd2250)));
    localparam logic [CW-1:0] H225_MAX = CW'(win_hi(nom_cyc(64'sd2250)));
    localparam logic [CW-1:0] T560_MIN = CW'(win_lo(nom_cyc(64'sd560)));
    localparam logic [CW-1:0] T560_MAX = CW'(win_hi(nom_cyc(64'sd560)));
    localparam logic [CW-1:0] T169_MIN = CW'(win_lo(nom_cyc(64'sd1690)));
    localparam logic [CW-1:0] T169_MAX = CW'(win_hi(nom_cyc(64'sd1690)));

    // millisecond prescaler and repeat-window counter sizing
    localparam int MS_CYC = (CLK_FREQ_HZ / 1000 > 0) ? (CLK_FREQ_HZ / 1000) : 1;
    localparam int PW     = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
    localparam int MW     = (RPT_WIN_MS > 1) ? $clog2(RPT_WIN_MS) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEAD_L = 3'd1;
    localparam logic [2:0] S_LEAD_H = 3'd2;
    localparam logic [2:0] S_BIT_L  = 3'd3;
    localparam logic [2:0] S_BIT_H  = 3'd4;
    localparam logic [2:0] S_STOP_L = 3'd5;
    localparam logic [2:0] S_RPT_L  = 3'd6;

    function automatic logic in_win(input logic [CW-1:0] c,
                                    input logic [CW-1:0] lo,
                                    input logic [CW-1:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

    // a byte and its transmitted complement must be exact bitwise inverses
    function automatic logic inv_ok(input logic [7:0] b, input logic [7:0] b_inv);
        return b_inv == ~b;
    endfunction

    logic [1:0]    sync_r;
    logic          prev_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    state_r, state_nxt_s;
    logic [4:0]    idx_r, idx_nxt_s;
    logic [31:0]   sr_r, sr_nxt_s;
    logic [15:0]   addr_nxt_s;
    logic [7:0]    cmd_nxt_s;
    logic          dv_nxt_s, rpt_nxt_s, err_nxt_s;
    logic          rpt_open_r;
    logic [PW-1:0] pre_r;
    logic [MW-1:0] ms_r;
    logic          fall_s, rise_s, edge_s, sat_s;
    logic          addr_ok_s;
    logic [15:0]   addr_val_s;

    assign fall_s = prev_r & ~sync_r[1];
    assign rise_s = ~prev_r & sync_r[1];
    assign edge_s = fall_s | rise_s;
    assign sat_s  = (cnt_r == SAT);

`ifdef IR_EXT_ADDR_EN
    assign addr_ok_s  = 1'b1;
    assign addr_val_s = sr_r[15:0];
`else
    assign addr_ok_s  = inv_ok(sr_r[7:0], sr_r[15:8]);
    assign addr_val_s = {8'h00, sr_r[7:0]};
`endif

    // synchronise the IR line, keep the previous sample for edge detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_r <= 2'b11;
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[0], inf_in};
            prev_r <= sync_r[1];
        end
    end

    // phase timer: cleared on each line edge, holds at saturation
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (edge_s) begin
            cnt_r <= {CW{1'b0}};
        end else if (!sat_s) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // protocol decoder: next state, shift data and output pulses
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        sr_nxt_s    = sr_r;
        addr_nxt_s  = addr;
        cmd_nxt_s   = cmd;
        dv_nxt_s    = 1'b0;
        rpt_nxt_s   = 1'b0;
        err_nxt_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (fall_s) state_nxt_s = S_LEAD_L;
                else        state_nxt_s = S_IDLE;
            end
            S_LEAD_L: begin
                if (rise_s) begin
                    if (in_win(cnt_r, L9_MIN, L9_MAX)) state_nxt_s = S_LEAD_H;
                    else                               state_nxt_s = S_IDLE;
                end else if (sat_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_LEAD_L;
                end
            end
            S_LEAD_H: begin
                if (fall_s) begin
                    if (in_win(cnt_r, H45_MIN, H45_MAX)) begin
                        state_nxt_s = S_BIT_L;
                        idx_nxt_s   = 5'd0;
                        sr_nxt_s    = 32'h0000_0000;
                    end else if (in_win(cnt_r, H225_MIN, H225_MAX)) begin
                        state_nxt_s = S_RPT_L;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end else if (sat_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_LEAD_H;
                end
            end
            S_BIT_L: begin
                if (rise_s) begin
                    if (in_win(cnt_r, T560_MIN, T560_MAX)) begin
                        state_nxt_s = S_BIT_H;
                    end else begin
                        state_nxt_s = S_IDLE;
                        err_nxt_s   = 1'b1;
                    end
                end else if (sat_s) begin
                    state_nxt_s = S_IDLE;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = S_BIT_L;
                end
            end
            S_BIT_H: begin
                if (fall_s) begin
                    if (in_win(cnt_r, T560_MIN, T560_MAX) || in_win(cnt_r, T169_MIN, T169_MAX)) begin
                        // LSB first: new bit enters at the top and walks down
                        sr_nxt_s = {in_win(cnt_r, T169_MIN, T169_MAX), sr_r[31:1]};
                        if (idx_r == 5'd31) begin
                            state_nxt_s = S_STOP_L;
                        end else begin
                            idx_nxt_s   = idx_r + 5'd1;
                            state_nxt_s = S_BIT_L;
                        end
                    end else begin
                        state_nxt_s = S_IDLE;
                        err_nxt_s   = 1'b1;
                    end
                end else if (sat_s) begin
                    state_nxt_s = S_IDLE;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = S_BIT_H;
                end
            end
            S_STOP_L: begin
                if (rise_s) begin
                    state_nxt_s = S_IDLE;
                    if (in_win(cnt_r, T560_MIN, T560_MAX) && addr_ok_s &&
                        inv_ok(sr_r[23:16], sr_r[31:24])) begin
                        dv_nxt_s   = 1'b1;
                        addr_nxt_s = addr_val_s;
                        cmd_nxt_s  = sr_r[23:16];
                    end else begin
                        err_nxt_s  = 1'b1;
                    end
                end else if (sat_s) begin
                    state_nxt_s = S_IDLE;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = S_STOP_L;
                end
            end
            S_RPT_L: begin
                if (rise_s) begin
                    state_nxt_s = S_IDLE;
                    rpt_nxt_s   = in_win(cnt_r, T560_MIN, T560_MAX) && rpt_open_r;
                end else if (sat_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_RPT_L;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // register decoder state and all outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r    <= S_IDLE;
            idx_r      <= 5'd0;
            sr_r       <= 32'h0000_0000;
            addr       <= 16'h0000;
            cmd        <= 8'h00;
            data_valid <= 1'b0;
            repeat_en  <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            sr_r       <= sr_nxt_s;
            addr       <= addr_nxt_s;
            cmd        <= cmd_nxt_s;
            data_valid <= dv_nxt_s;
            repeat_en  <= rpt_nxt_s;
            frame_err  <= err_nxt_s;
            busy       <= (state_nxt_s != S_IDLE);
        end
    end

    // repeat window: opened or restarted by an accepted frame or repeat, closed after RPT_WIN_MS ms
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rpt_open_r <= 1'b0;
            pre_r      <= {PW{1'b0}};
            ms_r       <= {MW{1'b0}};
        end else if (dv_nxt_s || rpt_nxt_s) begin
            rpt_open_r <= 1'b1;
            pre_r      <= {PW{1'b0}};
            ms_r       <= {MW{1'b0}};
        end else if (rpt_open_r) begin
            if (pre_r == PW'(MS_CYC - 1)) begin
                pre_r <= {PW{1'b0}};
                if (ms_r == MW'(RPT_WIN_MS - 1)) begin
                    rpt_open_r <= 1'b0;
                    ms_r       <= {MW{1'b0}};
                end else begin
                    ms_r <= ms_r + MW'(1);
                end
            end else begin
                pre_r <= pre_r + PW'(1);
            end
        end else begin
            pre_r <= {PW{1'b0}};
            ms_r  <= {MW{1'b0}};
        end
    end

endmodule

// File: tb/tb_nec_ir_rx.sv
// tb_nec_ir_rx: directed bench for nec_ir_rx. The receiver runs with
// CLK_FREQ_HZ = 100 kHz so one clock is 10 us: 9 ms = 900 cycles,
// 4.5 ms = 450, 2.25 ms = 225, 560 us = 56, 1690 us = 169, 1 ms = 100.
module tb_nec_ir_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inf_in = 1'b1;
    logic [15:0] addr;
    logic [7:0]  cmd;
    logic        data_valid, repeat_en, frame_err, busy;

    int checks = 0;
    int failures = 0;
    int dv_cnt = 0;
    int rpt_cnt = 0;
    int err_cnt = 0;

    nec_ir_rx #(
        .CLK_FREQ_HZ(100_000),
        .TOL_PCT    (20),
        .RPT_WIN_MS (120)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .inf_in    (inf_in),
        .addr      (addr),
        .cmd       (cmd),
        .data_valid(data_valid),
        .repeat_en (repeat_en),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // count high cycles of each pulse output, sampled away from the active edge
    always @(negedge clk) begin
        if (data_valid) dv_cnt++;
        if (repeat_en)  rpt_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic clear_counts();
        dv_cnt = 0;
        rpt_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic hold(input logic lvl, input int cyc);
        inf_in = lvl;
        repeat (cyc) @(negedge clk);
    endtask

    task automatic send_lead();
        hold(1'b0, 900);
        hold(1'b1, 450);
    endtask

    task automatic send_bit(input logic b);
        hold(1'b0, 56);
        hold(1'b1, b ? 169 : 56);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] ai,
                              input logic [7:0] c, input logic [7:0] ci);
        logic [31:0] w;
        w = {ci, c, ai, a};
        send_lead();
        for (int i = 0; i < 32; i++) send_bit(w[i]);
        hold(1'b0, 56);
        hold(1'b1, 10);
    endtask

    task automatic send_repeat();
        hold(1'b0, 900);
        hold(1'b1, 225);
        hold(1'b0, 56);
        hold(1'b1, 10);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        inf_in = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({addr, cmd, data_valid, repeat_en, frame_err, busy} !== 28'h0) begin
            failures++;
            $display("FAIL reset_outputs: got addr=%h cmd=%h dv=%b rpt=%b err=%b busy=%b, expected all 0",
                     addr, cmd, data_valid, repeat_en, frame_err, busy);
        end
        rst_n = 1'b1;
        hold(1'b1, 10);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_frame();
        clear_counts();
        send_frame(8'h57, 8'hA8, 8'h22, 8'hDD);
        checks++;
        if (dv_cnt !== 1 || err_cnt !== 0) begin
            failures++;
            $display("FAIL frame_pulses: got dv=%0d err=%0d expected dv=1 err=0", dv_cnt, err_cnt);
        end
        checks++;
        if (addr !== 16'h0057 || cmd !== 8'h22) begin
            failures++;
            $display("FAIL frame_data: got addr=%h cmd=%h expected 0057/22", addr, cmd);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL frame_busy_after: got %b expected 0", busy);
        end
    endtask

    task automatic test_repeat();
        clear_counts();
        hold(1'b1, 4200);
        send_repeat();
        checks++;
        if (rpt_cnt !== 1 || err_cnt !== 0 || dv_cnt !== 0) begin
            failures++;
            $display("FAIL repeat_pulses: got rpt=%0d err=%0d dv=%0d expected 1/0/0", rpt_cnt, err_cnt, dv_cnt);
        end
        checks++;
        if (addr !== 16'h0057 || cmd !== 8'h22) begin
            failures++;
            $display("FAIL repeat_data: got addr=%h cmd=%h expected 0057/22", addr, cmd);
        end
    endtask

    task automatic test_bad_cmd();
        clear_counts();
        hold(1'b1, 50);
        send_frame(8'h33, 8'hCC, 8'h44, 8'hBA);
        checks++;
        if (err_cnt !== 1 || dv_cnt !== 0) begin
            failures++;
            $display("FAIL badcmd_pulses: got err=%0d dv=%0d expected 1/0", err_cnt, dv_cnt);
        end
        checks++;
        if (addr !== 16'h0057 || cmd !== 8'h22) begin
            failures++;
            $display("FAIL badcmd_hold: got addr=%h cmd=%h expected 0057/22", addr, cmd);
        end
    endtask

    task automatic test_noise();
        clear_counts();
        hold(1'b0, 100);
        hold(1'b1, 50);
        checks++;
        if (err_cnt !== 0 || dv_cnt !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL noise_silent: got err=%0d dv=%0d busy=%b expected 0/0/0", err_cnt, dv_cnt, busy);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        send_lead();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        hold(1'b0, 56);
        hold(1'b1, 110);
        hold(1'b0, 56);
        hold(1'b1, 20);
        checks++;
        if (err_cnt !== 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_bad_bit: got err=%0d busy=%b expected 1/0", err_cnt, busy);
        end
        send_frame(8'h21, 8'hDE, 8'h9A, 8'h65);
        checks++;
        if (dv_cnt !== 1 || err_cnt !== 1 || addr !== 16'h0021 || cmd !== 8'h9A) begin
            failures++;
            $display("FAIL b2b_next_frame: got dv=%0d err=%0d addr=%h cmd=%h expected 1/1/0021/9A",
                     dv_cnt, err_cnt, addr, cmd);
        end
    endtask

    task automatic test_repeat_expired();
        clear_counts();
        send_frame(8'h10, 8'hEF, 8'h05, 8'hFA);
        checks++;
        if (dv_cnt !== 1 || addr !== 16'h0010 || cmd !== 8'h05) begin
            failures++;
            $display("FAIL expired_frame: got dv=%0d addr=%h cmd=%h expected 1/0010/05", dv_cnt, addr, cmd);
        end
        hold(1'b1, 15000);
        send_repeat();
        checks++;
        if (rpt_cnt !== 0 || err_cnt !== 0) begin
            failures++;
            $display("FAIL expired_repeat: got rpt=%0d err=%0d expected 0/0", rpt_cnt, err_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        clear_counts();
        send_lead();
        for (int i = 0; i < 12; i++) send_bit(i[0]);
        hold(1'b0, 20);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL midframe_busy: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({addr, cmd, data_valid, repeat_en, frame_err, busy} !== 28'h0) begin
            failures++;
            $display("FAIL midframe_reset: got addr=%h cmd=%h dv=%b rpt=%b err=%b busy=%b expected all 0",
                     addr, cmd, data_valid, repeat_en, frame_err, busy);
        end
        inf_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 300);
        checks++;
        if (dv_cnt !== 0 || err_cnt !== 0 || rpt_cnt !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midframe_no_pulse: got dv=%0d err=%0d rpt=%0d busy=%b expected 0/0/0/0",
                     dv_cnt, err_cnt, rpt_cnt, busy);
        end
        send_repeat();
        checks++;
        if (rpt_cnt !== 0 || err_cnt !== 0) begin
            failures++;
            $display("FAIL repeat_no_frame: got rpt=%0d err=%0d expected 0/0", rpt_cnt, err_cnt);
        end
        send_frame(8'h57, 8'hA8, 8'h22, 8'hDD);
        checks++;
        if (dv_cnt !== 1 || err_cnt !== 0 || addr !== 16'h0057 || cmd !== 8'h22) begin
            failures++;
            $display("FAIL after_reset_frame: got dv=%0d err=%0d addr=%h cmd=%h expected 1/0/0057/22",
                     dv_cnt, err_cnt, addr, cmd);
        end
    endtask

    task automatic test_ext_addr();
        clear_counts();
        hold(1'b1, 50);
        send_frame(8'h57, 8'h12, 8'h22, 8'hDD);
`ifdef IR_EXT_ADDR_EN
        checks++;
        if (dv_cnt !== 1 || err_cnt !== 0 || addr !== 16'h1257 || cmd !== 8'h22) begin
            failures++;
            $display("FAIL ext_addr: got dv=%0d err=%0d addr=%h cmd=%h expected 1/0/1257/22",
                     dv_cnt, err_cnt, addr, cmd);
        end
`else
        checks++;
        if (dv_cnt !== 0 || err_cnt !== 1 || addr !== 16'h0057 || cmd !== 8'h22) begin
            failures++;
            $display("FAIL std_addr_check: got dv=%0d err=%0d addr=%h cmd=%h expected 0/1/0057/22",
                     dv_cnt, err_cnt, addr, cmd);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_frame();
        test_repeat();
        test_bad_cmd();
        test_noise();
        test_back_to_back();
        test_repeat_expired();
        test_reset_midframe();
        test_ext_addr();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
